mux_rr_arbiter: RTL

- Round-robin arbiter and select controller for a shared four-input, one-output multiplexer.
- Four requesters compete for the mux output path. The block grants one requester at a time and drives the mux select pair s1/s0 to match the grant.
- It sits between the requesting sources and the mux select inputs. It also reports busy status to downstream logic.

---
 rtl/mux_rr_arbiter_if.sv | 21 ++
 rtl/mux_rr_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Bundle of request/grant/select signals between the requesters and the
// mux_rr_arbiter. The master side is the requester logic; the slave side is the arbiter.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, s1, s0, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, s1, s0, busy, timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux.
// One owner at a time. Each grant is followed by at least one idle cycle.
// Optional grant-hold timeout: define MUX_ARB_TIMEOUT_EN to build it in.
module mux_rr_arbiter #(
  parameter int CNT_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  mux_rr_arbiter_if.slave  arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic [1:0]       r_last;
  logic             r_busy;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_win;
  logic             w_hit;
  logic [1:0]       w_idx;
  logic             w_rel;
  logic             w_expire;

  // Reject illegal hold limits when the design is elaborated.
  if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD out of range 2..2^CNT_W");
  end

  // Pick the first requester after the last granted index, wrapping 3 -> 0.
  always_comb begin
    w_win = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_hit && arb.req[w_idx]) begin
        w_win = w_idx;
        w_hit = 1'b1;
      end
    end
  end

  // The owner lets go when it signals done or withdraws its request.
  always_comb begin
    w_rel = arb.done | ~arb.req[r_sel];
`ifdef MUX_ARB_TIMEOUT_EN
    w_expire = (r_cnt == CNT_W'(MAX_HOLD - 1));
`else
    w_expire = 1'b0;
`endif
  end

  // Arbitration FSM with registered grant, select, busy and timeout outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 2'd3;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_hit) begin
            r_grant <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_rel || w_expire) begin
            // A normal release on the expiry cycle is not flagged as a timeout.
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_last    <= r_sel;
            r_timeout <= ~w_rel;
            r_state   <= IDLE;
          end else begin
            r_timeout <= 1'b0;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arb.grant   = r_grant;
  assign arb.s1      = r_sel[1];
  assign arb.s0      = r_sel[0];
  assign arb.busy    = r_busy;
  assign arb.timeout = r_timeout;

endmodule
